// File: rtl/hyperram_target_model_if.sv
// HyperBus DDR-split bus between a HyperRAM controller (master) and a target (slave).
// Rise and fall halves of DQ/RWDS are carried separately, one bus cycle per clk with bus_ck_en.
interface hyperram_target_model_if;
  logic        bus_cs;
  logic        bus_ck_en;
  logic [15:0] bus_dq_in_rise;
  logic [15:0] bus_dq_in_fall;
  logic [15:0] bus_dq_out_rise;
  logic [15:0] bus_dq_out_fall;
  logic        bus_dq_oe;
  logic [1:0]  bus_rwds_out_rise;
  logic [1:0]  bus_rwds_out_fall;
  logic        bus_rwds_oe;

  modport master (
    output bus_cs, bus_ck_en, bus_dq_in_rise, bus_dq_in_fall,
    input  bus_dq_out_rise, bus_dq_out_fall, bus_dq_oe,
    input  bus_rwds_out_rise, bus_rwds_out_fall, bus_rwds_oe
  );

  modport slave (
    input  bus_cs, bus_ck_en, bus_dq_in_rise, bus_dq_in_fall,
    output bus_dq_out_rise, bus_dq_out_fall, bus_dq_oe,
    output bus_rwds_out_rise, bus_rwds_out_fall, bus_rwds_oe
  );
endinterface

// File: rtl/hyperram_target_model.sv
// HyperBus target model for one 16-bit HyperRAM: CA capture, initial latency,
// linear read/write bursts against an internal word array, and configuration register 0.
module hyperram_target_model #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 6,
  parameter logic [15:0] CR0_RESET  = 16'h8F1F
) (
  input  logic                    clk,
  input  logic                    rst,
  hyperram_target_model_if.slave  bus,
  input  logic                    force_2x,
  output logic [15:0]             cr0,
  output logic                    txn_done,
  output logic                    txn_abort
);
  localparam int unsigned          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]           LAT_1X   = 4'(LATENCY);
  localparam logic [3:0]           LAT_2X   = 4'(2 * LATENCY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CA0    = 4'd1,
    ST_CA1    = 4'd2,
    ST_CA2    = 4'd3,
    ST_LAT    = 4'd4,
    ST_RDATA  = 4'd5,
    ST_WDATA  = 4'd6,
    ST_REGWR  = 4'd7,
    ST_WAITCS = 4'd8
  } state_t;

  state_t                  state_r, state_s;
  logic [31:0]             ca_hi_r, ca_hi_s;
  logic                    lat2x_r, lat2x_s;
  logic [3:0]              cnt_r, cnt_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic                    is_rd_r, is_rd_s;
  logic                    is_reg_r, is_reg_s;
  logic                    armed_r, armed_s;
  logic [15:0]             cr0_r, cr0_s;
  logic [15:0]             dq_rise_r, dq_rise_s, dq_fall_r, dq_fall_s;
  logic                    dq_oe_r, dq_oe_s;
  logic [1:0]              rwds_rise_r, rwds_rise_s, rwds_fall_r, rwds_fall_s;
  logic                    rwds_oe_r, rwds_oe_s;
  logic                    done_r, done_s, abort_r, abort_s;
  logic                    mem_we_s;
  logic                    beat_s;
  logic [47:0]             ca_full_s;
  logic [31:0]             rd_word_s;
  logic [31:0]             mem_r [DEPTH];

  // Word address is {CA[44:16], CA[2:0]} truncated to the array depth.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [47:0] ca);
    logic [31:0] full;
    full = {ca[44:16], ca[2:0]};
    return full[ADDR_WIDTH-1:0];
  endfunction

  assign beat_s    = ~bus.bus_cs & bus.bus_ck_en;
  assign ca_full_s = {ca_hi_r, bus.bus_dq_in_rise[7:0], bus.bus_dq_in_fall[7:0]};
  assign rd_word_s = is_reg_r ? {cr0_r, cr0_r} : mem_r[addr_r];

  // Next-state and next-output logic; every register holds unless a bus beat moves it.
  always_comb begin
    state_s     = state_r;
    ca_hi_s     = ca_hi_r;
    lat2x_s     = lat2x_r;
    cnt_s       = cnt_r;
    addr_s      = addr_r;
    is_rd_s     = is_rd_r;
    is_reg_s    = is_reg_r;
    armed_s     = armed_r | bus.bus_cs;
    cr0_s       = cr0_r;
    dq_rise_s   = dq_rise_r;
    dq_fall_s   = dq_fall_r;
    dq_oe_s     = dq_oe_r;
    rwds_rise_s = rwds_rise_r;
    rwds_fall_s = rwds_fall_r;
    rwds_oe_s   = rwds_oe_r;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    mem_we_s    = 1'b0;
    // CS high outranks any beat arriving in the same cycle.
    if (bus.bus_cs && (state_r != ST_IDLE)) begin
      state_s   = ST_IDLE;
      dq_oe_s   = 1'b0;
      rwds_oe_s = 1'b0;
      if (state_r inside {ST_RDATA, ST_WDATA, ST_WAITCS}) begin
        done_s = 1'b1;
      end else begin
        abort_s = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          lat2x_s = 1'b0;
          if (!bus.bus_cs && armed_r) begin
            state_s     = ST_CA0;
            rwds_oe_s   = 1'b1;
            rwds_rise_s = 2'b00;
            rwds_fall_s = 2'b00;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CA0: begin
          if (beat_s) begin
            ca_hi_s[31:16] = {bus.bus_dq_in_rise[7:0], bus.bus_dq_in_fall[7:0]};
            lat2x_s        = force_2x;
            rwds_rise_s    = {2{force_2x}};
            rwds_fall_s    = {2{force_2x}};
            state_s        = ST_CA1;
          end else begin
            state_s = ST_CA0;
          end
        end
        ST_CA1: begin
          if (beat_s) begin
            ca_hi_s[15:0] = {bus.bus_dq_in_rise[7:0], bus.bus_dq_in_fall[7:0]};
            state_s       = ST_CA2;
          end else begin
            state_s = ST_CA1;
          end
        end
        ST_CA2: begin
          if (beat_s) begin
            is_rd_s   = ca_hi_r[31];
            is_reg_s  = ca_hi_r[30];
            addr_s    = word_addr(ca_full_s);
            cnt_s     = lat2x_r ? LAT_2X : LAT_1X;
            rwds_oe_s = 1'b0;
            if (!ca_hi_r[31] && ca_hi_r[30]) begin
              state_s = ST_REGWR;
            end else begin
              state_s = ST_LAT;
            end
          end else begin
            state_s = ST_CA2;
          end
        end
        ST_LAT: begin
          if (beat_s && (cnt_r == 4'd1)) begin
            if (is_rd_r) begin
              // Preload the first word so it is on the bus in the first data cycle.
              state_s     = ST_RDATA;
              dq_rise_s   = rd_word_s[31:16];
              dq_fall_s   = rd_word_s[15:0];
              dq_oe_s     = 1'b1;
              rwds_oe_s   = 1'b1;
              rwds_rise_s = 2'b11;
              rwds_fall_s = 2'b00;
              addr_s      = addr_r + ADDR_ONE;
            end else begin
              state_s = ST_WDATA;
            end
          end else if (beat_s) begin
            cnt_s = cnt_r - 4'd1;
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_RDATA: begin
          if (beat_s) begin
            dq_rise_s = rd_word_s[31:16];
            dq_fall_s = rd_word_s[15:0];
            addr_s    = addr_r + ADDR_ONE;
          end else begin
            addr_s = addr_r;
          end
        end
        ST_WDATA: begin
          if (beat_s) begin
            mem_we_s = 1'b1;
            addr_s   = addr_r + ADDR_ONE;
          end else begin
            mem_we_s = 1'b0;
          end
        end
        ST_REGWR: begin
          if (beat_s) begin
            cr0_s   = {bus.bus_dq_in_rise[7:0], bus.bus_dq_in_fall[7:0]};
            state_s = ST_WAITCS;
          end else begin
            state_s = ST_REGWR;
          end
        end
        ST_WAITCS: begin
          state_s = ST_WAITCS;
        end
        default: begin
          state_s   = ST_IDLE;
          dq_oe_s   = 1'b0;
          rwds_oe_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ca_hi_r     <= 32'd0;
      lat2x_r     <= 1'b0;
      cnt_r       <= 4'd0;
      addr_r      <= '0;
      is_rd_r     <= 1'b0;
      is_reg_r    <= 1'b0;
      armed_r     <= 1'b0;
      cr0_r       <= CR0_RESET;
      dq_rise_r   <= 16'd0;
      dq_fall_r   <= 16'd0;
      dq_oe_r     <= 1'b0;
      rwds_rise_r <= 2'b00;
      rwds_fall_r <= 2'b00;
      rwds_oe_r   <= 1'b0;
      done_r      <= 1'b0;
      abort_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      ca_hi_r     <= ca_hi_s;
      lat2x_r     <= lat2x_s;
      cnt_r       <= cnt_s;
      addr_r      <= addr_s;
      is_rd_r     <= is_rd_s;
      is_reg_r    <= is_reg_s;
      armed_r     <= armed_s;
      cr0_r       <= cr0_s;
      dq_rise_r   <= dq_rise_s;
      dq_fall_r   <= dq_fall_s;
      dq_oe_r     <= dq_oe_s;
      rwds_rise_r <= rwds_rise_s;
      rwds_fall_r <= rwds_fall_s;
      rwds_oe_r   <= rwds_oe_s;
      done_r      <= done_s;
      abort_r     <= abort_s;
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_r[addr_r] <= {bus.bus_dq_in_rise, bus.bus_dq_in_fall};
    end
  end

  assign bus.bus_dq_out_rise   = dq_rise_r;
  assign bus.bus_dq_out_fall   = dq_fall_r;
  assign bus.bus_dq_oe         = dq_oe_r;
  assign bus.bus_rwds_out_rise = rwds_rise_r;
  assign bus.bus_rwds_out_fall = rwds_fall_r;
  assign bus.bus_rwds_oe       = rwds_oe_r;
  assign cr0                   = cr0_r;
  assign txn_done              = done_r;
  assign txn_abort             = abort_r;
endmodule

// File: tb/tb_hyperram_target_model.sv
// Self-checking bench for hyperram_target_model: table-driven write/read bursts with a
// read-data scoreboard queue, plus hand sequences for register access, abort, gaps and reset.
module tb_hyperram_target_model;
  logic        clk = 1'b0;
  logic        rst;
  logic        force_2x;
  logic [15:0] cr0;
  logic        txn_done;
  logic        txn_abort;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [256];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [7:0]  addr;
    int          len;
    logic        f2x;
    logic [31:0] base;
    int          gap;
    int          exp_lat;
  } vec_t;
  vec_t vecs [4];

  hyperram_target_model_if bus_if ();

  hyperram_target_model #(
    .ADDR_WIDTH(8),
    .LATENCY   (6),
    .CR0_RESET (16'h8F1F)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .force_2x (force_2x),
    .cr0      (cr0),
    .txn_done (txn_done),
    .txn_abort(txn_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [15:0] r, input logic [15:0] f);
    bus_if.bus_dq_in_rise = r;
    bus_if.bus_dq_in_fall = f;
    bus_if.bus_ck_en      = 1'b1;
    tick();
    bus_if.bus_ck_en      = 1'b0;
  endtask

  function automatic logic [47:0] make_ca(input logic rd, input logic rg, input logic [7:0] a);
    logic [47:0] c;
    c        = 48'd0;
    c[47]    = rd;
    c[46]    = rg;
    c[20:16] = a[7:3];
    c[2:0]   = a[2:0];
    return c;
  endfunction

  task automatic cs_low();
    bus_if.bus_cs = 1'b0;
    tick();
    chk("ca0_rwds_oe", {63'd0, bus_if.bus_rwds_oe}, 64'd1);
  endtask

  task automatic send_ca(input logic [47:0] ca, input logic f2x);
    force_2x = f2x;
    beat({8'h00, ca[47:40]}, {8'h00, ca[39:32]});
    force_2x = 1'b0;
    chk("ca_rwds_oe", {63'd0, bus_if.bus_rwds_oe}, 64'd1);
    chk("ca_rwds", {60'd0, bus_if.bus_rwds_out_rise, bus_if.bus_rwds_out_fall}, {60'd0, {4{f2x}}});
    beat({8'h00, ca[31:24]}, {8'h00, ca[23:16]});
    chk("ca_rwds_oe2", {63'd0, bus_if.bus_rwds_oe}, 64'd1);
    beat({8'h00, ca[15:8]}, {8'h00, ca[7:0]});
    chk("lat_rwds_oe", {63'd0, bus_if.bus_rwds_oe}, 64'd0);
  endtask

  task automatic cs_high(input logic ck, input logic [31:0] d, input logic exp_done, input logic exp_abort);
    bus_if.bus_cs         = 1'b1;
    bus_if.bus_ck_en      = ck;
    bus_if.bus_dq_in_rise = d[31:16];
    bus_if.bus_dq_in_fall = d[15:0];
    tick();
    bus_if.bus_ck_en = 1'b0;
    chk("end_pulses", {62'd0, txn_done, txn_abort}, {62'd0, exp_done, exp_abort});
    chk("end_oe", {62'd0, bus_if.bus_dq_oe, bus_if.bus_rwds_oe}, 64'd0);
    tick();
    chk("pulse_clear", {62'd0, txn_done, txn_abort}, 64'd0);
  endtask

  task automatic write_burst(input logic [7:0] a, input int n, input logic [31:0] base, input int lat);
    logic [7:0]  wa;
    logic [31:0] d;
    cs_low();
    send_ca(make_ca(1'b0, 1'b0, a), 1'b0);
    repeat (lat) beat(16'hDEAD, 16'hBEEF);
    for (int i = 0; i < n; i++) begin
      wa = a + 8'(i);
      d  = base + 32'(i);
      model_mem[wa] = d;
      beat(d[31:16], d[15:0]);
      chk("wr_dq_oe", {63'd0, bus_if.bus_dq_oe}, 64'd0);
    end
    cs_high(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic read_burst(input logic [7:0] a, input int n, input logic f2x, input int gap,
                            input int lat, input logic rg, input logic [31:0] reg_val);
    logic [7:0]  ra;
    logic [31:0] e;
    cs_low();
    send_ca(make_ca(1'b1, rg, a), f2x);
    for (int i = 0; i < n; i++) begin
      ra = a + 8'(i);
      exp_q.push_back(rg ? reg_val : model_mem[ra]);
    end
    for (int k = 1; k < lat; k++) begin
      beat(16'h0000, 16'h0000);
      chk("lat_dq_oe", {63'd0, bus_if.bus_dq_oe}, 64'd0);
    end
    for (int i = 0; i < n; i++) begin
      beat(16'h0000, 16'h0000);
      repeat (gap) tick();
      chk("rd_oe_rwds", {58'd0, bus_if.bus_dq_oe, bus_if.bus_rwds_oe, bus_if.bus_rwds_out_rise, bus_if.bus_rwds_out_fall},
          {58'd0, 2'b11, 2'b11, 2'b00});
      e = exp_q.pop_front();
      chk("rd_data", {32'd0, bus_if.bus_dq_out_rise, bus_if.bus_dq_out_fall}, {32'd0, e});
    end
    cs_high(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    vecs[0] = '{addr: 8'h10, len: 3, f2x: 1'b0, base: 32'hA5A5_0001, gap: 0, exp_lat: 6};
    vecs[1] = '{addr: 8'hFE, len: 4, f2x: 1'b0, base: 32'h1234_0000, gap: 0, exp_lat: 6};
    vecs[2] = '{addr: 8'h40, len: 2, f2x: 1'b1, base: 32'hCAFE_0000, gap: 0, exp_lat: 12};
    vecs[3] = '{addr: 8'h80, len: 3, f2x: 1'b0, base: 32'h5555_0000, gap: 2, exp_lat: 6};

    rst = 1'b1;
    force_2x = 1'b0;
    bus_if.bus_cs = 1'b1;
    bus_if.bus_ck_en = 1'b0;
    bus_if.bus_dq_in_rise = 16'h0000;
    bus_if.bus_dq_in_fall = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_oe", {62'd0, bus_if.bus_dq_oe, bus_if.bus_rwds_oe}, 64'd0);
    chk("rst_dq", {32'd0, bus_if.bus_dq_out_rise, bus_if.bus_dq_out_fall}, 64'd0);
    chk("rst_rwds", {60'd0, bus_if.bus_rwds_out_rise, bus_if.bus_rwds_out_fall}, 64'd0);
    chk("rst_cr0", {48'd0, cr0}, {48'd0, 16'h8F1F});
    chk("rst_pulses", {62'd0, txn_done, txn_abort}, 64'd0);

    // Register write of CR0.
    cs_low();
    send_ca(48'h6000_0000_0800, 1'b0);
    chk("regwr_cr0_before", {48'd0, cr0}, {48'd0, 16'h8F1F});
    beat(16'h008F, 16'h00E7);
    chk("regwr_cr0", {48'd0, cr0}, {48'd0, 16'h8FE7});
    chk("regwr_dq_oe", {63'd0, bus_if.bus_dq_oe}, 64'd0);
    cs_high(1'b0, 32'd0, 1'b1, 1'b0);

    // Register read returns {cr0, cr0}.
    read_burst(8'h00, 2, 1'b0, 0, 6, 1'b1, 32'h8FE7_8FE7);

    for (int v = 0; v < 4; v++) begin
      write_burst(vecs[v].addr, vecs[v].len, vecs[v].base, 6);
      read_burst(vecs[v].addr, vecs[v].len, vecs[v].f2x, vecs[v].gap, vecs[v].exp_lat, 1'b0, 32'd0);
    end

    // Abort during write latency: array must stay untouched.
    cs_low();
    send_ca(make_ca(1'b0, 1'b0, 8'h10), 1'b0);
    beat(16'h0BAD, 16'h0BAD);
    beat(16'h0BAD, 16'h0BAD);
    cs_high(1'b0, 32'd0, 1'b0, 1'b1);
    read_burst(8'h10, 3, 1'b0, 1, 6, 1'b0, 32'd0);

    // CS rise coinciding with a data beat drops that beat.
    write_burst(8'h20, 2, 32'hB000_0000, 6);
    cs_low();
    send_ca(make_ca(1'b0, 1'b0, 8'h20), 1'b0);
    repeat (6) beat(16'h0000, 16'h0000);
    model_mem[8'h20] = 32'hC000_0000;
    beat(16'hC000, 16'h0000);
    cs_high(1'b1, 32'hD000_0001, 1'b1, 1'b0);
    read_burst(8'h20, 2, 1'b0, 0, 6, 1'b0, 32'd0);

    // Reset mid-transaction: no CA accepted until CS has been high again.
    bus_if.bus_cs = 1'b0;
    tick();
    beat(16'h0080, 16'h0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cr0", {48'd0, cr0}, {48'd0, 16'h8F1F});
    beat(16'h0080, 16'h0000);
    beat(16'h0000, 16'h0000);
    chk("mid_rst_idle_oe", {62'd0, bus_if.bus_dq_oe, bus_if.bus_rwds_oe}, 64'd0);
    bus_if.bus_cs = 1'b1;
    tick();
    chk("mid_rst_pulses", {62'd0, txn_done, txn_abort}, 64'd0);
    read_burst(8'h00, 1, 1'b0, 0, 6, 1'b1, 32'h8F1F_8F1F);
    read_burst(8'hFE, 4, 1'b0, 0, 6, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
